// File: rtl/unified_mem_arbiter_pkg.sv
// Shared encodings for the unified memory arbiter: response-owner tags and
// the byte-enable value used for reads and idle cycles.
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_D    = 2'd2
    } rsp_e;

    localparam logic [3:0] BYTEEN_NONE = 4'b0000;

endpackage

// File: rtl/unified_mem_arbiter_starve_ctr.sv
// Counts consecutive data grants taken while a fetch waits and raises
// force_if once that count reaches STARVE_MAX.
module arb_starve_ctr #(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic if_gnt,
    input  logic d_gnt,
    output logic force_if
);

    localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= 4'd0;
        end else if (if_gnt || !if_req) begin
            starve_cnt <= 4'd0;
        end else if (d_gnt && starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign force_if = (starve_cnt == CNT_MAX);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port, 1-cycle-latency memory between instruction fetch
// and the data port; data has priority with bounded fetch starvation.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [3:0]        d_byteen,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    input  logic              flush,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    logic force_if;
    logic if_active;
    logic d_active;
    rsp_e rsp_q;
    logic squash_q;

    arb_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve_ctr (
        .clk     (clk),
        .reset   (reset),
        .if_req  (if_req),
        .if_gnt  (if_gnt),
        .d_gnt   (d_gnt),
        .force_if(force_if)
    );

    // Grants are gated by reset so nothing reaches the macro while held in reset.
    assign if_active = reset & if_req & ~flush;
    assign d_active  = reset & d_req;

    assign if_gnt = if_active & (~d_active | force_if);
    assign d_gnt  = d_active & ~(if_active & force_if);

    assign mem_en    = if_gnt | d_gnt;
    assign mem_addr  = if_gnt ? if_addr : (d_gnt ? d_addr : '0);
    assign mem_we    = (d_gnt & d_we) ? d_byteen : BYTEEN_NONE;
    assign mem_wdata = mem_en ? d_wdata : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_q    <= RSP_NONE;
            squash_q <= 1'b0;
        end else begin
            squash_q <= flush;
            if (if_gnt)
                rsp_q <= RSP_IF;
            else if (d_gnt && !d_we)
                rsp_q <= RSP_D;
            else
                rsp_q <= RSP_NONE;
        end
    end

    // A flush arriving the cycle after a fetch grant kills that response directly.
    assign if_rvalid = (rsp_q == RSP_IF) & ~squash_q & ~flush;
    assign d_rvalid  = (rsp_q == RSP_D);
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench for unified_mem_arbiter against a behavioural model of the
// arbitration rules, plus directed scenarios with literal expectations.
module tb_unified_mem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int STARVE_MAX = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [3:0]        d_byteen;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              flush;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    unified_mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_byteen (d_byteen),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .flush    (flush),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Memory macro stand-in driven by the DUT's memory port.
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we != 4'b0000) begin
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem[mem_addr[5:2]];
            end
        end
    end

    // Reference model state.
    logic [31:0] m_mem [16];
    int          m_starve;
    int          m_owner;     // 0 none, 1 fetch, 2 load
    bit          m_squash;
    logic [31:0] m_exp_data;

    // Snapshots of DUT outputs taken at the falling edge of the last cycle.
    logic s_if_gnt, s_d_gnt, s_if_rvalid, s_d_rvalid, s_mem_en;
    logic [3:0]  s_mem_we;
    logic [31:0] s_mem_addr, s_mem_wdata, s_if_rdata, s_d_rdata;

    function automatic logic [31:0] init_word(int i);
        return (32'h0101_0101 * i) ^ 32'hA5C3_0F00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        bit          ia, da, frc, ig, dg, irv, drv;
        logic [3:0]  e_we;
        logic [31:0] e_addr, e_wdata;
        int          idx;
        @(negedge clk);
        if (!reset) begin
            m_starve = 0;
            m_owner  = 0;
            m_squash = 0;
        end
        frc = (m_starve >= STARVE_MAX);
        ia  = reset && if_req && !flush;
        da  = reset && d_req;
        ig  = ia && (!da || frc);
        dg  = da && !(ia && frc);
        e_addr  = ig ? if_addr : (dg ? d_addr : 32'd0);
        e_we    = (dg && d_we) ? d_byteen : 4'b0000;
        e_wdata = (ig || dg) ? d_wdata : 32'd0;
        irv = (m_owner == 1) && !flush && !m_squash;
        drv = (m_owner == 2);

        s_if_gnt = if_gnt;       s_d_gnt = d_gnt;
        s_if_rvalid = if_rvalid; s_d_rvalid = d_rvalid;
        s_mem_en = mem_en;       s_mem_we = mem_we;
        s_mem_addr = mem_addr;   s_mem_wdata = mem_wdata;
        s_if_rdata = if_rdata;   s_d_rdata = d_rdata;

        chk("if_gnt", 32'(if_gnt), 32'(ig));
        chk("d_gnt", 32'(d_gnt), 32'(dg));
        chk("mem_en", 32'(mem_en), 32'(ig || dg));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("if_rvalid", 32'(if_rvalid), 32'(irv));
        chk("d_rvalid", 32'(d_rvalid), 32'(drv));
        if (irv) chk("if_rdata", if_rdata, m_exp_data);
        if (drv) chk("d_rdata", d_rdata, m_exp_data);

        @(posedge clk);
        if (reset) begin
            m_squash = flush;
            if (ig) begin
                m_owner = 1;
                m_exp_data = m_mem[if_addr[5:2]];
            end else if (dg && !d_we) begin
                m_owner = 2;
                m_exp_data = m_mem[d_addr[5:2]];
            end else begin
                m_owner = 0;
            end
            if (dg && d_we) begin
                idx = int'(d_addr[5:2]);
                for (int b = 0; b < 4; b++)
                    if (d_byteen[b]) m_mem[idx][8*b +: 8] = d_wdata[8*b +: 8];
            end
            if (ig || !if_req)
                m_starve = 0;
            else if (dg && m_starve < STARVE_MAX)
                m_starve = m_starve + 1;
        end else begin
            m_starve = 0;
            m_owner  = 0;
            m_squash = 0;
        end
        #1;
    endtask

    string seq;

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]   = init_word(i);
            m_mem[i] = init_word(i);
        end
        mem_rdata = 32'd0;
        m_starve = 0; m_owner = 0; m_squash = 0; m_exp_data = 32'd0;
        reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h0000_0004;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0010;
        d_byteen = 4'hF; d_wdata = 32'h1234_5678; flush = 1'b0;

        // Reset held with both requesters active.
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst_if_gnt", 32'(s_if_gnt), 32'd0);
            chk("rst_d_gnt", 32'(s_d_gnt), 32'd0);
            chk("rst_mem_en", 32'(s_mem_en), 32'd0);
            chk("rst_mem_we", 32'(s_mem_we), 32'd0);
            chk("rst_rvalid", 32'({s_if_rvalid, s_d_rvalid}), 32'd0);
        end
        reset = 1'b1;

        // Starvation: both held, data wins STARVE_MAX times then fetch is forced.
        seq = "";
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (i == 0) chk("first_d_gnt", 32'(s_d_gnt), 32'd1);
            seq = {seq, s_d_gnt ? "D" : (s_if_gnt ? "I" : "-")};
        end
        vectors++;
        if (seq != "DDDIDDDI") begin
            miscompares++;
            $display("FAIL starve_seq: got %s required DDDIDDDI", seq);
        end

        // Fetch only.
        d_req = 1'b0; if_req = 1'b1; if_addr = 32'h0000_3000;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("fetch_gnt", 32'(s_if_gnt), 32'd1);
            chk("fetch_addr", s_mem_addr, 32'h0000_3000);
            if (i > 0) chk("fetch_rvalid", 32'(s_if_rvalid), 32'd1);
        end
        if_req = 1'b0;
        cycle();
        chk("fetch_last_rvalid", 32'(s_if_rvalid), 32'd1);
        chk("fetch_last_rdata", s_if_rdata, init_word(0));

        // Store.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0010;
        d_byteen = 4'b0011; d_wdata = 32'hDEAD_BEEF;
        cycle();
        chk("store_gnt", 32'(s_d_gnt), 32'd1);
        chk("store_we", 32'(s_mem_we), 32'h3);
        chk("store_wdata", s_mem_wdata, 32'hDEAD_BEEF);
        d_req = 1'b0; d_we = 1'b0;
        cycle();
        chk("store_no_rvalid", 32'(s_d_rvalid), 32'd0);

        // Flush squashes a fetch granted the cycle before.
        if_req = 1'b1; if_addr = 32'h0000_0020;
        cycle();
        chk("flush_n_gnt", 32'(s_if_gnt), 32'd1);
        flush = 1'b1;
        cycle();
        chk("flush_n1_rvalid", 32'(s_if_rvalid), 32'd0);
        chk("flush_n1_gnt", 32'(s_if_gnt), 32'd0);
        flush = 1'b0;
        cycle();
        chk("flush_n2_gnt", 32'(s_if_gnt), 32'd1);
        if_req = 1'b0;
        cycle();
        chk("flush_n3_rvalid", 32'(s_if_rvalid), 32'd1);

        // Load response and fetch grant overlap.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0008;
        cycle();
        chk("mix_d_gnt", 32'(s_d_gnt), 32'd1);
        d_req = 1'b0; if_req = 1'b1; if_addr = 32'h0000_000C;
        cycle();
        chk("mix_d_rvalid", 32'(s_d_rvalid), 32'd1);
        chk("mix_d_rdata", s_d_rdata, init_word(2));
        chk("mix_if_gnt", 32'(s_if_gnt), 32'd1);
        chk("mix_if_rvalid_early", 32'(s_if_rvalid), 32'd0);
        if_req = 1'b0;
        cycle();
        chk("mix_if_rvalid", 32'(s_if_rvalid), 32'd1);
        chk("mix_if_rdata", s_if_rdata, init_word(3));
        chk("mix_d_rvalid_late", 32'(s_d_rvalid), 32'd0);

        // Reset in the middle of a pending load discards the response.
        d_req = 1'b1; d_addr = 32'h0000_0004;
        cycle();
        d_req = 1'b0;
        reset = 1'b0;
        cycle();
        chk("midrst_d_rvalid", 32'(s_d_rvalid), 32'd0);
        reset = 1'b1;
        cycle();
        chk("midrst_after", 32'(s_d_rvalid), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if (!if_req || s_if_gnt || (flush && $urandom_range(0, 1) == 1)) begin
                if_req  = ($urandom_range(0, 99) < 60);
                if_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            end
            if (!d_req || s_d_gnt) begin
                d_req    = ($urandom_range(0, 99) < 55);
                d_we     = $urandom_range(0, 2) == 0;
                d_addr   = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                d_byteen = 4'($urandom_range(0, 15));
                d_wdata  = $urandom;
            end
            flush = ($urandom_range(0, 99) < 10);
            reset = ($urandom_range(0, 499) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
